// File: rtl/strobe_bus_sync_if.sv
// Bus-side signals of strobe_bus_sync: the asynchronous source bus and the
// coherent synchronized copy with its update strobe and busy flag.
interface strobe_bus_sync_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] bus_in;
    logic [WIDTH-1:0] synchronized_bus;
    logic             strobe_out;
    logic             busy;

    // The source drives bus_in and observes the result.
    modport master (
        output bus_in,
        input  synchronized_bus,
        input  strobe_out,
        input  busy
    );

    // The synchronizer samples bus_in and presents the coherent copy.
    modport slave (
        input  bus_in,
        output synchronized_bus,
        output strobe_out,
        output busy
    );
endinterface

// File: rtl/strobe_bus_sync.sv
// Strobe-based bus synchronizer: a stable, changed bus value is held and a toggle
// request crosses a flop chain; its arrival loads the held value onto the output in one cycle.
module strobe_bus_sync #(
    parameter int WIDTH       = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    strobe_bus_sync_if.slave bus
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [WIDTH-1:0]       in_q;
    logic [WIDTH-1:0]       in_qq;
    logic [WIDTH-1:0]       hold_q;
    logic [WIDTH-1:0]       sync_bus_q;
    logic                   strobe_q;

    logic                   req;
    logic [SYNC_STAGES-1:0] req_sync;
    logic                   req_d;

    logic                   stable;
    logic                   launch;
    logic                   update;

    // Two equal consecutive samples mean the source has settled on a value.
    assign stable = (in_q == in_qq);
    assign update = (req_sync[SYNC_STAGES-1] != req_d);

    // NOTE: every flop, including the request chain, is cleared asynchronously so a
    // reset mid-transfer leaves no toggle in flight to fire a stale update afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q  <= '0;
            in_qq <= '0;
        end else begin
            // NOTE: non-blocking, so in_qq receives last cycle's in_q, not this edge's sample.
            in_q  <= bus.bus_in;
            in_qq <= in_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: defaults first, so every path assigns state_d and launch and no latch is inferred.
    always_comb begin
        state_d = state_q;
        launch  = 1'b0;
        case (state_q)
            IDLE: begin
                if (stable && (in_qq != hold_q)) begin
                    launch  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (update) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // hold_q moves only at launch, so the output can only ever take a settled value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            req    <= 1'b0;
        end else if (launch) begin
            hold_q <= in_qq;
            req    <= ~req;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_sync <= '0;
            req_d    <= 1'b0;
        end else begin
            req_sync <= {req_sync[SYNC_STAGES-2:0], req};
            req_d    <= req_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_bus_q <= '0;
            strobe_q   <= 1'b0;
        end else begin
            strobe_q <= update;
            if (update) begin
                sync_bus_q <= hold_q;
            end
        end
    end

    assign bus.synchronized_bus = sync_bus_q;
    assign bus.strobe_out       = strobe_q;
    assign bus.busy             = (state_q == BUSY);

    // The update edge both pulses the strobe and ends the transfer.
    a_strobe_not_busy : assert property (
        @(posedge clk) disable iff (rst) bus.strobe_out |-> !bus.busy
    );

    a_strobe_single : assert property (
        @(posedge clk) disable iff (rst) bus.strobe_out |=> !bus.strobe_out
    );

endmodule

// File: tb/tb_strobe_bus_sync.sv
// Randomized scoreboard bench for strobe_bus_sync: two instances (2 and 3 sync stages)
// share one bus_in and are checked against a cycle-level reference of the transfer rules.
module tb_strobe_bus_sync;

    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] val;
        int               cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             rst_probe = 1'b0;
    logic             drain_chk = 1'b0;
    logic             drain_done = 1'b0;
    logic [WIDTH-1:0] bus_in = '0;

    int n_cmp = 0;
    int n_bad = 0;

    strobe_bus_sync_if #(.WIDTH(WIDTH)) bif0 ();
    strobe_bus_sync_if #(.WIDTH(WIDTH)) bif1 ();

    assign bif0.bus_in = bus_in;
    assign bif1.bus_in = bus_in;

    strobe_bus_sync #(.WIDTH(WIDTH), .SYNC_STAGES(2)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bif0.slave)
    );

    strobe_bus_sync #(.WIDTH(WIDTH), .SYNC_STAGES(3)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bif1.slave)
    );

    always #5 clk = ~clk;

    logic [1:0][WIDTH-1:0] sbus;
    logic [1:0]            strb;
    logic [1:0]            bsy;
    assign sbus = {bif1.synchronized_bus, bif0.synchronized_bus};
    assign strb = {bif1.strobe_out, bif0.strobe_out};
    assign bsy  = {bif1.busy, bif0.busy};

    function automatic int stages(input int k);
        return (k == 0) ? 2 : 3;
    endfunction

    // ---------------- reference model ----------------
    // A value launches once it has been sampled twice in a row, differs from the last
    // launched value and no transfer is open; it appears stages+1 edges after launch.
    int               cyc = 0;
    logic [WIDTH-1:0] smp_new = '0;
    logic [WIDTH-1:0] smp_old = '0;
    logic [WIDTH-1:0] m_hold [2];
    int               m_until [2];
    logic [1:0]       m_open = '0;
    logic [1:0]       exp_busy = '0;
    exp_t             exp_q [2][$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_new  <= '0;
            smp_old  <= '0;
            m_open   <= '0;
            exp_busy <= '0;
            for (int k = 0; k < 2; k++) begin
                m_hold[k]  <= '0;
                m_until[k] <= 0;
            end
        end else begin
            cyc <= cyc + 1;
            for (int k = 0; k < 2; k++) begin
                if ((smp_new == smp_old) && (smp_old != m_hold[k]) &&
                    (!m_open[k] || ((cyc + 1) > m_until[k]))) begin
                    m_hold[k]   <= smp_old;
                    m_until[k]  <= cyc + 1 + stages(k) + 1;
                    m_open[k]   <= 1'b1;
                    exp_busy[k] <= 1'b1;
                    exp_q[k].push_back('{val: smp_old, cyc: cyc + 1 + stages(k) + 1});
                end else begin
                    exp_busy[k] <= m_open[k] && ((cyc + 1) < m_until[k]);
                end
            end
            smp_old <= smp_new;
            smp_new <= bus_in;
        end
    end

    // ---------------- monitor / scoreboard ----------------
    task automatic check(input string name, input int lane,
                         input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s lane%0d cycle %0d: got %0h, required %0h",
                     name, lane, cyc, act, req);
        end
    endtask

    logic [WIDTH-1:0] last [2];
    int               rd_idx [2];
    exp_t             e;

    initial begin
        for (int k = 0; k < 2; k++) begin
            last[k]   = '0;
            rd_idx[k] = 0;
        end
    end

    always @(negedge clk or posedge rst_probe) begin
        if (clk) begin
            // Reset was raised mid-cycle: outputs must already be clear.
            for (int k = 0; k < 2; k++) begin
                check("async_reset_bus", k, 32'(sbus[k]), 32'd0);
                check("async_reset_strobe", k, 32'(strb[k]), 32'd0);
                check("async_reset_busy", k, 32'(bsy[k]), 32'd0);
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (rst) begin
                    check("reset_bus", k, 32'(sbus[k]), 32'd0);
                    check("reset_strobe", k, 32'(strb[k]), 32'd0);
                    check("reset_busy", k, 32'(bsy[k]), 32'd0);
                    last[k]   = '0;
                    rd_idx[k] = exp_q[k].size();
                end else begin
                    if (strb[k]) begin
                        if (rd_idx[k] >= exp_q[k].size()) begin
                            check("unexpected_strobe", k, 32'(strb[k]), 32'd0);
                        end else begin
                            e = exp_q[k][rd_idx[k]];
                            rd_idx[k]++;
                            check("strobe_cycle", k, 32'(cyc), 32'(e.cyc));
                            check("strobe_value", k, 32'(sbus[k]), 32'(e.val));
                            last[k] = e.val;
                        end
                    end else begin
                        if ((rd_idx[k] < exp_q[k].size()) && (exp_q[k][rd_idx[k]].cyc < cyc)) begin
                            check("missed_strobe", k, 32'(strb[k]), 32'd1);
                            rd_idx[k]++;
                        end
                        check("bus_hold", k, 32'(sbus[k]), 32'(last[k]));
                    end
                    check("busy", k, 32'(bsy[k]), 32'(exp_busy[k]));
                end
                if (drain_chk && !drain_done) begin
                    check("pending_at_end", k, 32'(exp_q[k].size() - rd_idx[k]), 32'd0);
                end
            end
            if (drain_chk) begin
                drain_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    // Inputs change 1 time unit after the falling edge, clear of both sampling points.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    initial begin
        int hold;
        rst    = 1'b1;
        bus_in = '0;
        step(3);
        rst = 1'b0;
        step(5);

        bus_in = 4'b1010;
        step(10);

        // Second value arrives while the first transfer is busy.
        bus_in = 4'b0011;
        step(2);
        bus_in = 4'b0101;
        step(16);

        for (int i = 0; i < 20; i++) begin
            bus_in = (i % 2 == 1) ? 4'b1111 : 4'b0000;
            step(1);
        end
        bus_in = 4'b1111;
        step(12);

        // Reset at E3 of a 4'b0110 transfer, then a fresh transfer with the same value.
        bus_in = 4'b0110;
        step(3);
        @(posedge clk);
        #1 rst = 1'b1;
        #1 rst_probe = 1'b1;
        step(1);
        rst_probe = 1'b0;
        step(1);
        rst = 1'b0;
        step(12);

        for (int i = 0; i < 40; i++) begin
            bus_in = WIDTH'($urandom);
            hold   = int'($urandom_range(1, 10));
            step(hold);
        end

        step(20);
        drain_chk = 1'b1;
        step(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
